// File: rtl/avalon_st_packet_gen.sv
// avalon_st_packet_gen: Avalon-ST counted packet source with Avalon-MM CSR control
module avalon_st_packet_gen #(
  parameter int DATA_BYTES = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [DATA_BYTES*8-1:0]       stream_out_data,
  output logic [$clog2(DATA_BYTES)-1:0] stream_out_empty,
  output logic                          stream_out_valid,
  output logic                          stream_out_startofpacket,
  output logic                          stream_out_endofpacket,
  input  logic                          stream_out_ready,
  input  logic [1:0]                    csr_address,
  input  logic                          csr_read,
  input  logic                          csr_write,
  input  logic [31:0]                   csr_writedata,
  output logic [31:0]                   csr_readdata,
  output logic                          csr_readdatavalid,
  output logic                          csr_waitrequest
);
  localparam int EW = $clog2(DATA_BYTES);
  localparam int DW = DATA_BYTES * 8;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, n_state;
  logic [15:0] len_r, count_r, run_len, run_count, pkt_idx, beat_idx, gap_cnt;
  logic [15:0] n_len, n_count, n_pkt, n_beat, n_gap, n_last, neg_len;
  logic [31:0] sent, n_sent, rd_mux;
  logic busy, go, xfer, last_beat, n_send;

  function automatic logic [15:0] beats(input logic [15:0] l);
    logic [16:0] t;
    t = {1'b0, l} + 17'(DATA_BYTES - 1);
    return 16'(t >> EW);
  endfunction

  function automatic logic [DW-1:0] beat_data(input logic [15:0] p, input logic [15:0] b, input logic [15:0] l);
    logic [DW-1:0] d;
    logic [31:0] k;
    d = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      k = 32'(b) * 32'(DATA_BYTES) + 32'(i);
      d[DW-8-8*i +: 8] = k < 32'(l) ? p[7:0] + k[7:0] : 8'd0;
    end
    return d;
  endfunction

  assign csr_waitrequest = reset;
  assign busy = state != IDLE;
  assign xfer = state == SEND && stream_out_ready;
  assign last_beat = beat_idx == beats(run_len) - 16'd1;
  assign go = csr_write && csr_address == 2'd0 && csr_writedata[0] && !busy && len_r != 16'd0 && count_r != 16'd0;
  assign rd_mux = csr_address == 2'd0 ? {30'b0, busy, 1'b0} :
                  csr_address == 2'd1 ? {16'b0, len_r} :
                  csr_address == 2'd2 ? {16'b0, count_r} : sent;

  always_comb begin
    n_state = state;
    n_len = run_len;
    n_count = run_count;
    n_pkt = pkt_idx;
    n_beat = beat_idx;
    n_gap = gap_cnt;
    n_sent = sent;
    if (go) begin
      n_state = SEND;
      n_len = len_r;
      n_count = count_r;
      n_pkt = '0;
      n_beat = '0;
      n_sent = '0;
    end else if (xfer && !last_beat) begin
      n_beat = beat_idx + 16'd1;
    end else if (xfer) begin
      n_sent = sent + 32'd1;
      n_pkt = pkt_idx + 16'd1;
      n_beat = '0;
      n_gap = '0;
      n_state = pkt_idx + 16'd1 == run_count ? IDLE : (GAP_CYCLES > 0 ? GAP : SEND);
    end else if (state == GAP) begin
      n_gap = gap_cnt + 16'd1;
      n_state = gap_cnt == 16'(GAP_CYCLES - 1) ? SEND : GAP;
    end
    n_send = n_state == SEND;
    n_last = beats(n_len) - 16'd1;
    neg_len = 16'd0 - n_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      len_r <= 16'(DATA_BYTES);
      count_r <= 16'd1;
      run_len <= '0;
      run_count <= '0;
      pkt_idx <= '0;
      beat_idx <= '0;
      gap_cnt <= '0;
      sent <= '0;
      stream_out_valid <= 1'b0;
      stream_out_data <= '0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket <= 1'b0;
      stream_out_empty <= '0;
      csr_readdata <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      state <= n_state;
      run_len <= n_len;
      run_count <= n_count;
      pkt_idx <= n_pkt;
      beat_idx <= n_beat;
      gap_cnt <= n_gap;
      sent <= n_sent;
      stream_out_valid <= n_send;
      stream_out_data <= n_send ? beat_data(n_pkt, n_beat, n_len) : '0;
      stream_out_startofpacket <= n_send && n_beat == 16'd0;
      stream_out_endofpacket <= n_send && n_beat == n_last;
      stream_out_empty <= n_send && n_beat == n_last ? neg_len[EW-1:0] : '0;
      if (csr_write && !busy && csr_address == 2'd1) len_r <= csr_writedata[15:0];
      if (csr_write && !busy && csr_address == 2'd2) count_r <= csr_writedata[15:0];
      csr_readdatavalid <= csr_read;
      csr_readdata <= csr_read ? rd_mux : '0;
    end
  end
endmodule

// File: tb/tb_avalon_st_packet_gen.sv
// tb_avalon_st_packet_gen: directed and randomized checks of the packet source against a byte-level model
module tb_avalon_st_packet_gen;
  localparam int DB = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic [63:0] data [2];
  logic [2:0] empty [2];
  logic valid [2], sop [2], eop [2], rdv [2], wreq [2];
  logic ready [2] = '{1'b1, 1'b1};
  logic rd [2], wr [2];
  logic [1:0] addr [2];
  logic [31:0] wdata [2], rdata [2];
  int checks = 0, passes = 0;
  logic [68:0] obs0 [$], obs1 [$], exp_q [$];
  int eop_cnt [2], exp_cnt [2], idle [2];
  int gap_exp [2] = '{1, 0};
  bit gapping [2], in_pkt [2], held [2], rnd [2];
  logic [68:0] hold_v [2];

  avalon_st_packet_gen #(.DATA_BYTES(DB), .GAP_CYCLES(1)) u0 (
    .clk(clk), .reset(reset), .stream_out_data(data[0]), .stream_out_empty(empty[0]),
    .stream_out_valid(valid[0]), .stream_out_startofpacket(sop[0]), .stream_out_endofpacket(eop[0]),
    .stream_out_ready(ready[0]), .csr_address(addr[0]), .csr_read(rd[0]), .csr_write(wr[0]),
    .csr_writedata(wdata[0]), .csr_readdata(rdata[0]), .csr_readdatavalid(rdv[0]), .csr_waitrequest(wreq[0]));

  avalon_st_packet_gen #(.DATA_BYTES(DB), .GAP_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .stream_out_data(data[1]), .stream_out_empty(empty[1]),
    .stream_out_valid(valid[1]), .stream_out_startofpacket(sop[1]), .stream_out_endofpacket(eop[1]),
    .stream_out_ready(ready[1]), .csr_address(addr[1]), .csr_read(rd[1]), .csr_write(wr[1]),
    .csr_writedata(wdata[1]), .csr_readdata(rdata[1]), .csr_readdatavalid(rdv[1]), .csr_waitrequest(wreq[1]));

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) ready[u] = rnd[u] ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    logic [68:0] cur;
    for (int u = 0; u < 2; u++) begin
      cur = {sop[u], eop[u], empty[u], data[u]};
      if (reset) begin
        in_pkt[u] = 0;
        held[u] = 0;
        gapping[u] = 0;
      end else begin
        if (held[u]) chk("stall_hold", {valid[u], cur}, {1'b1, hold_v[u]});
        if (in_pkt[u]) chk("no_valid_drop", valid[u], 1);
        if (valid[u] && gapping[u]) begin
          chk("gap_len", idle[u], gap_exp[u]);
          gapping[u] = 0;
        end else if (gapping[u]) idle[u]++;
        if (valid[u] && ready[u]) begin
          if (u == 0) obs0.push_back(cur);
          else obs1.push_back(cur);
          if (sop[u]) in_pkt[u] = 1;
          if (eop[u]) begin
            in_pkt[u] = 0;
            eop_cnt[u]++;
            if (eop_cnt[u] < exp_cnt[u]) begin
              gapping[u] = 1;
              idle[u] = 0;
            end
          end
        end
        held[u] = valid[u] && !ready[u];
        hold_v[u] = cur;
      end
    end
  end

  function automatic void model(int len, int cnt);
    int nb, k;
    logic [63:0] d;
    exp_q.delete();
    nb = (len + DB - 1) / DB;
    for (int p = 0; p < cnt; p++)
      for (int b = 0; b < nb; b++) begin
        d = '0;
        for (int i = 0; i < DB; i++) begin
          k = b * DB + i;
          if (k < len) d[63-8*i -: 8] = 8'((p + k) % 256);
        end
        exp_q.push_back({b == 0, b == nb - 1, 3'(b == nb - 1 ? nb * DB - len : 0), d});
      end
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input int u, input logic [1:0] a, input logic [31:0] d);
    addr[u] = a;
    wdata[u] = d;
    wr[u] = 1'b1;
    tick();
    wr[u] = 1'b0;
  endtask

  task automatic csr_rd(input int u, input logic [1:0] a, input string tag, input logic [31:0] exp);
    addr[u] = a;
    rd[u] = 1'b1;
    tick();
    rd[u] = 1'b0;
    chk({tag, "_rdv"}, rdv[u], 1);
    chk(tag, rdata[u], exp);
  endtask

  task automatic start(input int u, input int len, input int cnt, input bit r);
    if (u == 0) obs0.delete();
    else obs1.delete();
    eop_cnt[u] = 0;
    exp_cnt[u] = cnt;
    rnd[u] = r;
    csr_wr(u, 1, len);
    csr_wr(u, 2, cnt);
    csr_wr(u, 0, 1);
    chk("first_valid", valid[u], 1);
  endtask

  task automatic finish(input int u, input int len, input int cnt);
    int n = 0;
    logic [68:0] got [$];
    while ((eop_cnt[u] < cnt || valid[u]) && n < 5000) begin
      tick();
      n++;
    end
    chk("run_timeout", n < 5000, 1);
    rnd[u] = 0;
    model(len, cnt);
    if (u == 0) got = obs0;
    else got = obs1;
    chk("beat_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk($sformatf("beat%0d", i), got[i], exp_q[i]);
    csr_rd(u, 3, "sent_done", cnt);
    csr_rd(u, 0, "ctrl_done", 0);
  endtask

  initial begin
    int len, cnt;
    rd = '{1'b0, 1'b0};
    wr = '{1'b0, 1'b0};
    addr = '{2'd0, 2'd0};
    wdata = '{32'd0, 32'd0};
    rnd = '{1'b0, 1'b0};
    reset = 1'b1;
    #1;
    chk("waitreq_in_reset", {wreq[0], wreq[1]}, 2'b11);
    chk("valid_in_reset", valid[0], 0);
    tick(2);
    reset = 1'b0;
    #1;
    chk("waitreq_released", wreq[0], 0);
    tick();
    csr_rd(0, 0, "ctrl_rst", 0);
    csr_rd(0, 1, "len_rst", 8);
    csr_rd(0, 2, "cnt_rst", 1);
    csr_rd(0, 3, "sent_rst", 0);

    start(0, 16, 1, 0);
    chk("len16_beat0", {sop[0], eop[0], empty[0], data[0]}, {1'b1, 1'b0, 3'd0, 64'h0001020304050607});
    tick();
    chk("len16_beat1", {sop[0], eop[0], empty[0], data[0]}, {1'b0, 1'b1, 3'd0, 64'h08090A0B0C0D0E0F});
    finish(0, 16, 1);

    start(0, 13, 3, 0);
    finish(0, 13, 3);
    chk("len13_empty", obs0[1][66:64], 3);
    chk("len13_pad", obs0[1][23:0], 0);
    chk("len13_pkt2_first", obs0[4][63:56], 8'h02);

    start(0, 13, 3, 1);
    finish(0, 13, 3);
    repeat (4) begin
      len = $urandom_range(1, 40);
      cnt = $urandom_range(1, 4);
      start(0, len, cnt, 1);
      finish(0, len, cnt);
    end

    start(1, 5, 2, 0);
    finish(1, 5, 2);
    start(1, 20, 3, 1);
    finish(1, 20, 3);

    start(0, 40, 3, 0);
    csr_wr(0, 0, 1);
    csr_wr(0, 1, 7);
    csr_wr(0, 2, 9);
    csr_rd(0, 1, "len_busy", 40);
    csr_rd(0, 2, "cnt_busy", 3);
    csr_rd(0, 0, "ctrl_busy", 2);
    finish(0, 40, 3);
    csr_wr(0, 2, 0);
    csr_wr(0, 0, 1);
    chk("go_cnt0_valid", valid[0], 0);
    csr_rd(0, 0, "ctrl_cnt0", 0);
    csr_rd(0, 2, "cnt_zero", 0);
    csr_wr(0, 2, 1);
    csr_wr(0, 1, 0);
    csr_wr(0, 0, 1);
    chk("go_len0_valid", valid[0], 0);

    csr_wr(0, 1, 64);
    csr_wr(0, 0, 1);
    tick(2);
    chk("midpkt_valid", valid[0], 1);
    #2 reset = 1'b1;
    #1;
    chk("reset_async", {valid[0], sop[0], eop[0], empty[0], data[0]}, 0);
    tick();
    reset = 1'b0;
    tick();
    csr_rd(0, 1, "len_after_rst", 8);
    csr_rd(0, 2, "cnt_after_rst", 1);
    csr_rd(0, 3, "sent_after_rst", 0);
    csr_rd(0, 0, "ctrl_after_rst", 0);
    tick(3);
    chk("no_resume", valid[0], 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end
endmodule
